// File: rtl/rr_arb_burst_pkg.sv
// Purpose: shared types and helpers for the burst round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Upper bound on requester count supported by onehot2bin.
    localparam int MAX_N = 64;
    localparam int MAX_W = 6;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Binary index of a one-hot vector; only the low n bits are considered.
    function automatic logic [MAX_W-1:0] onehot2bin(input logic [MAX_N-1:0] oh, input int n);
        logic [MAX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && oh[i]) begin
                idx = idx | MAX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb_burst_if.sv
// Purpose: requester/resource handshake bundle between the arbiter and its clients.
// Latency: n/a (wires only).
// Backpressure: rsrc_ready stalls beats; grant is held while stalled.
interface rr_arb_burst_if
    import rr_arb_pkg::*;
#(
    parameter int N  = 7,
    parameter int QW = 4
);
    localparam int W = idx_w(N);

    logic [N-1:0]    req;
    logic [N-1:0]    req_last;
    logic [N*QW-1:0] cfg_quota;
    logic            rsrc_ready;
    logic [N-1:0]    grant;
    logic            grant_vld;
    logic [W-1:0]    grant_id;
    logic            beat;

    modport master (
        output req, req_last, cfg_quota, rsrc_ready,
        input  grant, grant_vld, grant_id, beat
    );

    modport slave (
        input  req, req_last, cfg_quota, rsrc_ready,
        output grant, grant_vld, grant_id, beat
    );

endinterface

// File: rtl/rr_arb_burst_pick.sv
// Purpose: round-robin winner pick -- lowest request above ptr, else lowest request.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed by the FSM only when idle.
module rr_arb_pick
    import rr_arb_pkg::*;
#(
    parameter int N = 7,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] win_oh,
    output logic [W-1:0] win_idx,
    output logic         any
);

    logic [N-1:0] masked;
    logic [N-1:0] sel;

    // Prefer requesters above the last winner, wrap to the lowest otherwise.
    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (i > int'(ptr));
        end
        sel     = (|masked) ? masked : req;
        win_oh  = sel & (~sel + N'(1));
        win_idx = W'(onehot2bin(MAX_N'(win_oh), N));
        any     = |req;
    end

endmodule

// File: rtl/rr_arb_burst.sv
// Purpose: burst-granular round-robin arbiter with per-requester beat quota.
// Latency: req->grant 1 cycle; release->next grant 2 edges (one idle bubble).
// Backpressure: rsrc_ready low stalls beats; grant held, quota counts beats only.
module rr_arb_burst
    import rr_arb_pkg::*;
#(
    parameter int REQ_NUM = 7,
    parameter int QW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb_burst_if.slave arb
);

    localparam int W = idx_w(REQ_NUM);

    state_e               state_q, state_d;
    logic [REQ_NUM-1:0]   grant_q, grant_d;
    logic [W-1:0]         grant_id_q, grant_id_d;
    logic [W-1:0]         ptr_q, ptr_d;
    logic [QW-1:0]        quota_q, quota_d;
    logic [QW-1:0]        cnt_q, cnt_d;

    logic [REQ_NUM-1:0]   win_oh;
    logic [W-1:0]         win_idx;
    logic                 win_any;
    logic                 cur_req;
    logic                 cur_last;
    logic                 beat;
    logic                 release_now;

    rr_arb_pick #(.N(REQ_NUM), .W(W)) u_pick (
        .req     (arb.req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (win_any)
    );

    // Next-state: grab a winner when idle, hold and count beats when busy.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        ptr_d       = ptr_q;
        quota_d     = quota_q;
        cnt_d       = cnt_q;
        release_now = 1'b0;
        cur_req     = arb.req[grant_id_q];
        cur_last    = arb.req_last[grant_id_q];
        beat        = (|grant_q) & cur_req & arb.rsrc_ready;

        case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d    = BUSY;
                    grant_d    = win_oh;
                    grant_id_d = win_idx;
                    quota_d    = arb.cfg_quota[int'(win_idx)*QW +: QW];
                    cnt_d      = '0;
                end
            end
            BUSY: begin
                // Priority: abandoned request, last beat, then quota exhaustion.
                if (!cur_req) begin
                    release_now = 1'b1;
                end else if (beat && cur_last) begin
                    release_now = 1'b1;
                end else if (beat && (quota_q != '0) &&
                             (({1'b0, cnt_q} + (QW+1)'(1)) == {1'b0, quota_q})) begin
                    release_now = 1'b1;
                end else if (beat) begin
                    cnt_d = (cnt_q == {QW{1'b1}}) ? cnt_q : cnt_q + QW'(1);
                end

                if (release_now) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    ptr_d      = grant_id_q;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; pointer resets to the top so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ptr_q      <= W'(REQ_NUM - 1);
            quota_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            quota_q    <= quota_d;
            cnt_q      <= cnt_d;
        end
    end

    assign arb.grant     = grant_q;
    assign arb.grant_vld = |grant_q;
    assign arb.grant_id  = grant_id_q;
    assign arb.beat      = beat;

endmodule

// File: tb/tb_rr_arb_burst.sv
module tb_rr_arb_burst;
    import rr_arb_pkg::*;

    localparam int N  = 7;
    localparam int QW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arb_burst_if #(.N(N), .QW(QW)) arb ();

    rr_arb_burst #(.REQ_NUM(N), .QW(QW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the resource, how many beats it has used,
    // and the requester that owned it last (fairness pointer).
    bit m_busy;
    int m_id;
    int m_ptr;
    int m_quota;
    int m_beats;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_id    = 0;
        m_ptr   = N - 1;
        m_quota = 0;
        m_beats = 0;
    endtask

    // Circular scan starting just after the last owner.
    function automatic int model_pick();
        for (int j = 1; j <= N; j++) begin
            int idx;
            idx = (m_ptr + j) % N;
            if (arb.req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_edge();
        if (!m_busy) begin
            int w;
            w = model_pick();
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_id    = w;
                m_quota = int'(arb.cfg_quota[w*QW +: QW]);
                m_beats = 0;
            end
        end else begin
            bit b;
            bit rel;
            b   = arb.req[m_id] && arb.rsrc_ready;
            rel = 1'b0;
            if (!arb.req[m_id]) rel = 1'b1;
            else if (b && arb.req_last[m_id]) rel = 1'b1;
            else if (b && m_quota != 0 && m_beats + 1 == m_quota) rel = 1'b1;
            else if (b) m_beats++;
            if (rel) begin
                m_busy = 1'b0;
                m_ptr  = m_id;
            end
        end
    endtask

    // One clock cycle: check beat before the edge, outputs just after it.
    task automatic step();
        logic exp_beat;
        #1;
        exp_beat = m_busy && arb.req[m_id] && arb.rsrc_ready;
        chk("beat", 32'(arb.beat), 32'(exp_beat));
        model_edge();
        @(posedge clk);
        #1;
        chk("grant", 32'(arb.grant), m_busy ? (32'd1 << m_id) : 32'd0);
        chk("grant_vld", 32'(arb.grant_vld), 32'(m_busy));
        chk("grant_id", 32'(arb.grant_id), m_busy ? 32'(m_id) : 32'd0);
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic rdy);
        arb.req        = r;
        arb.req_last   = l;
        arb.rsrc_ready = rdy;
        step();
    endtask

    task automatic set_quota(input int i, input int v);
        arb.cfg_quota[i*QW +: QW] = QW'(v);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        arb.req        = '0;
        arb.req_last   = '0;
        arb.rsrc_ready = 1'b0;
        model_reset();
        #1;
        chk("rst grant", 32'(arb.grant), 32'd0);
        chk("rst vld", 32'(arb.grant_vld), 32'd0);
        chk("rst id", 32'(arb.grant_id), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int order[$];
        int runlen[$];
        int cur;
        bit prev;
        int hc;
        logic [N-1:0] r;
        logic [N-1:0] l;

        arb.req        = '0;
        arb.req_last   = '0;
        arb.rsrc_ready = 1'b0;
        arb.cfg_quota  = '0;
        model_reset();

        // Two requesters, unlimited quota, last flag on the third beat.
        do_reset();
        cyc(7'b0000101, 7'b0, 1'b1);
        chk("t1 first grant", 32'(arb.grant), 32'h01);
        cyc(7'b0000101, 7'b0, 1'b1);
        cyc(7'b0000101, 7'b0, 1'b1);
        chk("t1 hold grant", 32'(arb.grant), 32'h01);
        cyc(7'b0000101, 7'b0000001, 1'b1);
        chk("t1 bubble", 32'(arb.grant), 32'h00);
        cyc(7'b0000101, 7'b0, 1'b1);
        chk("t1 second grant", 32'(arb.grant), 32'h04);
        cyc(7'b0, 7'b0, 1'b1);
        cyc(7'b0, 7'b0, 1'b1);

        // Everyone requesting, quota 2: strict rotation, 2-beat holds.
        do_reset();
        for (int i = 0; i < N; i++) set_quota(i, 2);
        cur  = 0;
        prev = 1'b0;
        for (int k = 0; k < 24; k++) begin
            cyc(7'b1111111, 7'b0, 1'b1);
            if (arb.grant_vld === 1'b1) begin
                if (!prev) order.push_back(int'(arb.grant_id));
                cur++;
            end else if (prev) begin
                runlen.push_back(cur);
                cur = 0;
            end
            prev = (arb.grant_vld === 1'b1);
        end
        chk("t2 grants", 32'(order.size()), 32'd8);
        chk("t2 runs", 32'(runlen.size()), 32'd8);
        for (int k = 0; k < order.size(); k++) chk("t2 order", 32'(order[k]), 32'(k % N));
        for (int k = 0; k < runlen.size(); k++) chk("t2 runlen", 32'(runlen[k]), 32'd2);
        cyc(7'b0, 7'b0, 1'b1);

        // Stalled beats do not count and stalled last does not release.
        do_reset();
        for (int i = 0; i < N; i++) set_quota(i, 0);
        set_quota(3, 3);
        hc = 0;
        cyc(7'b0001000, 7'b0, 1'b1);        if (arb.grant_vld === 1'b1) hc++;
        cyc(7'b0001000, 7'b0, 1'b1);        if (arb.grant_vld === 1'b1) hc++;
        cyc(7'b0001000, 7'b0001000, 1'b0);  if (arb.grant_vld === 1'b1) hc++;
        chk("t3 stalled last", 32'(arb.grant), 32'h08);
        cyc(7'b0001000, 7'b0, 1'b1);        if (arb.grant_vld === 1'b1) hc++;
        cyc(7'b0001000, 7'b0, 1'b0);        if (arb.grant_vld === 1'b1) hc++;
        cyc(7'b0001000, 7'b0, 1'b1);        if (arb.grant_vld === 1'b1) hc++;
        chk("t3 held cycles", 32'(hc), 32'd5);
        chk("t3 released", 32'(arb.grant), 32'h00);
        cyc(7'b0, 7'b0, 1'b1);

        // Owner drops request mid-burst; pointer lands on 5 so 6 wins next.
        do_reset();
        cyc(7'b0100000, 7'b0, 1'b1);
        chk("t4 grant5", 32'(arb.grant), 32'h20);
        cyc(7'b0100000, 7'b0, 1'b1);
        cyc(7'b1000001, 7'b0, 1'b1);
        chk("t4 abandon", 32'(arb.grant), 32'h00);
        cyc(7'b1000001, 7'b0, 1'b1);
        chk("t4 next6", 32'(arb.grant), 32'h40);
        cyc(7'b0, 7'b0, 1'b1);
        cyc(7'b0, 7'b0, 1'b1);

        // Quota change mid-burst applies only to the following grant.
        do_reset();
        set_quota(1, 4);
        cyc(7'b0000010, 7'b0, 1'b1);
        cyc(7'b0000010, 7'b0, 1'b1);
        set_quota(1, 1);
        cyc(7'b0000010, 7'b0, 1'b1);
        cyc(7'b0000010, 7'b0, 1'b1);
        chk("t5 old quota holds", 32'(arb.grant), 32'h02);
        cyc(7'b0000010, 7'b0, 1'b1);
        chk("t5 release after 4", 32'(arb.grant), 32'h00);
        cyc(7'b0000010, 7'b0, 1'b1);
        chk("t5 regrant", 32'(arb.grant), 32'h02);
        cyc(7'b0000010, 7'b0, 1'b1);
        chk("t5 single beat", 32'(arb.grant), 32'h00);
        cyc(7'b0, 7'b0, 1'b1);

        // Asynchronous reset in the middle of a burst.
        do_reset();
        set_quota(4, 0);
        cyc(7'b0010000, 7'b0, 1'b1);
        cyc(7'b0010000, 7'b0, 1'b1);
        chk("t6 pre-reset", 32'(arb.grant), 32'h10);
        rst_n = 1'b0;
        #1;
        chk("t6 async grant", 32'(arb.grant), 32'h00);
        chk("t6 async vld", 32'(arb.grant_vld), 32'd0);
        model_reset();
        arb.req = 7'b1111111;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(7'b1111111, 7'b0, 1'b1);
        chk("t6 first after reset", 32'(arb.grant), 32'h01);
        cyc(7'b0, 7'b0, 1'b1);
        cyc(7'b0, 7'b0, 1'b1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < N; i++) set_quota(i, $urandom_range(0, 3));
        r = '0;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
                l[i] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 7) == 0) set_quota($urandom_range(0, N-1), $urandom_range(0, 15));
            cyc(r, l, ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
